// File: rtl/mp_add_seq.sv
// mp_add_seq: streams multi-word operands (LS word first) through one fa_nbit
// adder, chaining each word's carry-out into the next word. Sum words leave on
// a single-stage registered valid/ready stream; the final word carries
// out_last and the operand's overall carry-out on out_co.
//
// FSM states
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_FIRST | next accepted word is word 0; adder carry-in comes from in_ci
//   ST_CHAIN | mid-operand; adder carry-in comes from carry_q of prior word

module fa_nbit #(
    parameter int WIDTH = 12
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    logic [WIDTH:0] sum;

    assign sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
    assign s   = sum[WIDTH-1:0];
    assign co  = sum[WIDTH];

endmodule

module mp_add_seq #(
    parameter int WIDTH = 12,
    parameter int WORDS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_ci,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_last,
    output logic             out_co
);

    localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);

    typedef enum logic {
        ST_FIRST = 1'b0,
        ST_CHAIN = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             carry_q;
    logic             carry_d;

    logic             add_ci;
    logic [WIDTH-1:0] add_s;
    logic             add_co;
    logic             accept;
    logic             is_last;

    // Output register is the only pipeline stage, so a drain frees it for an
    // accept in the same cycle. This is the sole combinational in->out path.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign is_last  = (word_cnt == LAST_CNT);

    fa_nbit #(
        .WIDTH(WIDTH)
    ) u_fa (
        .a  (in_a),
        .b  (in_b),
        .ci (add_ci),
        .s  (add_s),
        .co (add_co)
    );

    // Sequencer state register: operand phase, word index and chained carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_FIRST;
            word_cnt <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            word_cnt <= cnt_d;
            carry_q  <= carry_d;
        end
    end

    // Next-state logic and adder carry-in select; flush outranks an accept.
    always_comb begin
        state_d = state_q;
        cnt_d   = word_cnt;
        carry_d = carry_q;
        add_ci  = in_ci;

        case (state_q)
            ST_FIRST: add_ci = in_ci;
            ST_CHAIN: add_ci = carry_q;
            default:  add_ci = in_ci;
        endcase

        if (flush) begin
            state_d = ST_FIRST;
            cnt_d   = '0;
            carry_d = 1'b0;
        end else if (accept) begin
            if (is_last) begin
                // Operand complete: leftover carry must not leak into the
                // next operand, which takes its carry from in_ci instead.
                state_d = ST_FIRST;
                cnt_d   = '0;
                carry_d = 1'b0;
            end else begin
                state_d = ST_CHAIN;
                cnt_d   = word_cnt + CNT_W'(1);
                carry_d = add_co;
            end
        end
    end

    // Output stage: load on accept, drop valid on drain, clear on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_s     <= '0;
            out_last  <= 1'b0;
            out_co    <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_co    <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_s     <= add_s;
            out_last  <= is_last;
            out_co    <= is_last && add_co;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mp_add_seq.sv
// Bench for mp_add_seq (WIDTH=12, WORDS=4). Expected sums come from a whole
// operand addition at 49 bits, split back into 12-bit words.

module tb_mp_add_seq;

    localparam int WIDTH = 12;
    localparam int WORDS = 4;

    typedef logic [WIDTH-1:0] word_arr_t [WORDS];

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             last;
        logic             co;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_ci;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_s;
    logic             out_last;
    logic             out_co;

    int vectors     = 0;
    int miscompares = 0;

    logic             obs_valid [WORDS];
    logic             obs_last  [WORDS];
    logic             obs_co    [WORDS];
    logic [WIDTH-1:0] obs_s     [WORDS];

    mp_add_seq #(
        .WIDTH(WIDTH),
        .WORDS(WORDS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_ci     (in_ci),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .out_last  (out_last),
        .out_co    (out_co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [48:0] ref_sum(input word_arr_t a, input word_arr_t b, input logic ci);
        logic [47:0] av;
        logic [47:0] bv;
        for (int i = 0; i < WORDS; i++) begin
            av[12*i +: 12] = a[i];
            bv[12*i +: 12] = b[i];
        end
        return {1'b0, av} + {1'b0, bv} + 49'(ci);
    endfunction

    // Drive one operand with out_ready held high; record each word as shown.
    // in_ci is inverted on later words to show it is ignored there.
    task automatic run_op(input word_arr_t a, input word_arr_t b, input logic ci, input int gaps);
        in_valid = 1'b1;
        in_a     = a[0];
        in_b     = b[0];
        in_ci    = ci;
        for (int i = 0; i < WORDS; i++) begin
            @(negedge clk);
            obs_valid[i] = out_valid;
            obs_s[i]     = out_s;
            obs_last[i]  = out_last;
            obs_co[i]    = out_co;
            if (i < WORDS - 1) begin
                if (gaps > 0) begin
                    in_valid = 1'b0;
                    in_a     = 12'($urandom);
                    in_b     = 12'($urandom);
                    in_ci    = ~ci;
                    repeat (gaps) @(negedge clk);
                end
                in_valid = 1'b1;
                in_a     = a[i+1];
                in_b     = b[i+1];
                in_ci    = ~ci;
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        vectors++;
        if (out_valid !== 1'b0 || out_s !== 12'h000 || out_last !== 1'b0 ||
            out_co !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_values: got valid=%b s=%h last=%b co=%b rdy=%b, want 0 000 0 0 1",
                     out_valid, out_s, out_last, out_co, in_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_carry_ripple();
        word_arr_t a = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
        word_arr_t b = '{12'h001, 12'h000, 12'h000, 12'h000};
        run_op(a, b, 1'b0, 0);
        for (int i = 0; i < WORDS; i++) begin
            vectors++;
            if (obs_valid[i] !== 1'b1 || obs_s[i] !== 12'h000 || obs_last[i] !== (i == 3) ||
                obs_co[i] !== (i == 3)) begin
                miscompares++;
                $display("FAIL ripple_word%0d: got valid=%b s=%h last=%b co=%b, want 1 000 %0d %0d",
                         i, obs_valid[i], obs_s[i], obs_last[i], obs_co[i], i == 3, i == 3);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_no_carry();
        word_arr_t a    = '{12'h123, 12'h456, 12'h789, 12'h0AB};
        word_arr_t b    = '{12'h111, 12'h222, 12'h333, 12'h444};
        word_arr_t want = '{12'h235, 12'h678, 12'hABC, 12'h4EF};
        run_op(a, b, 1'b1, 0);
        for (int i = 0; i < WORDS; i++) begin
            vectors++;
            if (obs_valid[i] !== 1'b1 || obs_s[i] !== want[i] || obs_last[i] !== (i == 3) ||
                obs_co[i] !== 1'b0) begin
                miscompares++;
                $display("FAIL nocarry_word%0d: got valid=%b s=%h last=%b co=%b, want 1 %h %0d 0",
                         i, obs_valid[i], obs_s[i], obs_last[i], obs_co[i], want[i], i == 3);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        word_arr_t   a = '{12'h001, 12'hFFF, 12'h123, 12'h456};
        word_arr_t   b = '{12'h002, 12'h001, 12'h111, 12'h0AA};
        logic [48:0] sum;
        sum = ref_sum(a, b, 1'b0);
        in_valid = 1'b1; in_a = a[0]; in_b = b[0]; in_ci = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out_s !== sum[11:0]) begin
            miscompares++;
            $display("FAIL bp_word0: got valid=%b s=%h, want 1 %h", out_valid, out_s, sum[11:0]);
        end
        in_a = a[1]; in_b = b[1]; in_ci = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_a = a[2]; in_b = b[2]; in_ci = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b0 || out_s !== sum[23:12]) begin
            miscompares++;
            $display("FAIL bp_word1: got rdy=%b s=%h, want 0 %h", in_ready, out_s, sum[23:12]);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_s !== sum[23:12] || out_last !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold%0d: got rdy=%b valid=%b s=%h last=%b, want 0 1 %h 0",
                         k, in_ready, out_valid, out_s, out_last, sum[23:12]);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out_s !== sum[35:24] || out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_word2: got valid=%b s=%h last=%b, want 1 %h 0",
                     out_valid, out_s, out_last, sum[35:24]);
        end
        in_a = a[3]; in_b = b[3];
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out_s !== sum[47:36] || out_last !== 1'b1 || out_co !== sum[48]) begin
            miscompares++;
            $display("FAIL bp_word3: got valid=%b s=%h last=%b co=%b, want 1 %h 1 %b",
                     out_valid, out_s, out_last, out_co, sum[47:36], sum[48]);
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        word_arr_t   a1 = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
        word_arr_t   b1 = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
        word_arr_t   a2 = '{12'h0F0, 12'h800, 12'h7FF, 12'h001};
        word_arr_t   b2 = '{12'hF0F, 12'h800, 12'h000, 12'h002};
        logic [48:0] sum;
        run_op(a1, b1, 1'b0, 0);
        sum = ref_sum(a1, b1, 1'b0);
        vectors++;
        if (obs_s[3] !== sum[47:36] || obs_co[3] !== sum[48] || obs_last[3] !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_op1_last: got s=%h co=%b last=%b, want %h %b 1",
                     obs_s[3], obs_co[3], obs_last[3], sum[47:36], sum[48]);
        end
        run_op(a2, b2, 1'b1, 2);
        sum = ref_sum(a2, b2, 1'b1);
        for (int i = 0; i < WORDS; i++) begin
            vectors++;
            if (obs_valid[i] !== 1'b1 || obs_s[i] !== sum[12*i +: 12] || obs_last[i] !== (i == 3) ||
                obs_co[i] !== ((i == 3) ? sum[48] : 1'b0)) begin
                miscompares++;
                $display("FAIL b2b_op2_word%0d: got valid=%b s=%h last=%b co=%b, want 1 %h %0d %b",
                         i, obs_valid[i], obs_s[i], obs_last[i], obs_co[i], sum[12*i +: 12],
                         i == 3, (i == 3) ? sum[48] : 1'b0);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_abort(input logic use_flush);
        word_arr_t   a = '{12'h3C5, 12'hA5A, 12'hFFF, 12'h5A5};
        word_arr_t   b = '{12'h0AA, 12'h5A5, 12'h001, 12'h123};
        logic [48:0] sum;
        in_valid = 1'b1; in_a = 12'hFFF; in_b = 12'h001; in_ci = 1'b1;
        @(negedge clk);
        in_a = 12'hFFF; in_b = 12'hFFF; in_ci = 1'b0;
        @(negedge clk);
        if (use_flush) begin
            flush = 1'b1;
            in_a  = 12'h777; in_b = 12'h888;
            @(negedge clk);
            flush    = 1'b0;
            in_valid = 1'b0;
        end else begin
            in_valid = 1'b0;
            #2;
            rst_n = 1'b0;
            #1;
        end
        vectors++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_co !== 1'b0 || in_ready !== 1'b1 ||
            (!use_flush && out_s !== 12'h000)) begin
            miscompares++;
            $display("FAIL abort_outputs(flush=%b): got valid=%b s=%h last=%b co=%b rdy=%b, want 0 %s 0 0 1",
                     use_flush, out_valid, out_s, out_last, out_co, in_ready, use_flush ? "any" : "000");
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(a, b, 1'b1, 0);
        sum = ref_sum(a, b, 1'b1);
        for (int i = 0; i < WORDS; i++) begin
            vectors++;
            if (obs_valid[i] !== 1'b1 || obs_s[i] !== sum[12*i +: 12] || obs_last[i] !== (i == 3) ||
                obs_co[i] !== ((i == 3) ? sum[48] : 1'b0)) begin
                miscompares++;
                $display("FAIL abort_next(flush=%b)_word%0d: got valid=%b s=%h last=%b co=%b, want 1 %h %0d %b",
                         use_flush, i, obs_valid[i], obs_s[i], obs_last[i], obs_co[i],
                         sum[12*i +: 12], i == 3, (i == 3) ? sum[48] : 1'b0);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        exp_t        q[$];
        exp_t        e;
        word_arr_t   a;
        word_arr_t   b;
        logic        ci;
        logic [48:0] sum;
        logic        r;
        logic        v;
        logic        exp_rdy;
        int          ops = 0;
        int          wi  = 0;
        int          cyc = 0;
        for (int i = 0; i < WORDS; i++) begin
            a[i] = 12'($urandom);
            b[i] = 12'($urandom);
        end
        ci  = 1'($urandom);
        sum = ref_sum(a, b, ci);
        while ((ops < 200 || q.size() > 0) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            r = ($urandom_range(0, 3) != 0);
            out_ready = r;
            #1;
            exp_rdy = !out_valid || r;
            vectors++;
            if (in_ready !== exp_rdy) begin
                miscompares++;
                $display("FAIL rand_in_ready: got %b, want %b (cycle %0d)", in_ready, exp_rdy, cyc);
            end
            if (out_valid === 1'b1 && r) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rand_extra_word: got s=%h with nothing expected", out_s);
                end else begin
                    e = q.pop_front();
                    if (out_s !== e.s || out_last !== e.last || out_co !== e.co) begin
                        miscompares++;
                        $display("FAIL rand_word: got s=%h last=%b co=%b, want %h %b %b (op %0d)",
                                 out_s, out_last, out_co, e.s, e.last, e.co, ops);
                    end
                end
            end
            v = (ops < 200) && ($urandom_range(0, 3) != 0);
            in_valid = v;
            in_a  = v ? a[wi] : 12'($urandom);
            in_b  = v ? b[wi] : 12'($urandom);
            in_ci = (wi == 0) ? ci : 1'($urandom);
            if (v && exp_rdy) begin
                e.s    = sum[12*wi +: 12];
                e.last = (wi == WORDS - 1);
                e.co   = (wi == WORDS - 1) ? sum[48] : 1'b0;
                q.push_back(e);
                wi++;
                if (wi == WORDS) begin
                    wi = 0;
                    ops++;
                    for (int i = 0; i < WORDS; i++) begin
                        a[i] = 12'($urandom);
                        b[i] = 12'($urandom);
                    end
                    ci  = 1'($urandom);
                    sum = ref_sum(a, b, ci);
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (cyc >= 20000) begin
            vectors++;
            miscompares++;
            $display("FAIL rand_timeout: got %0d ops with %0d words pending, want 200 ops drained",
                     ops, q.size());
        end
        @(negedge clk);
    endtask

    initial begin
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_ci     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_carry_ripple();
        test_no_carry();
        test_backpressure();
        test_back_to_back();
        test_abort(1'b0);
        test_abort(1'b1);
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
